// File: rtl/branch_predict_resolver.sv
// branch_predict_resolver
//   Bimodal branch predictor with EX-stage resolution. The ID stage looks up a
//   table of 2-bit saturating counters to get predict_taken. The EX stage
//   compares the carried prediction with the real outcome, trains the table,
//   raises a one-cycle registered redirect on a mispredict, and counts
//   resolved branches and mispredictions.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   id_lookup_valid     ID holds a branch that needs a prediction
//   id_lookup_pc        PC of the ID-stage branch
//   predict_taken       combinational prediction for the ID branch
//   ex_branch_inst      EX holds a real branch (0 for bubbles)
//   ex_branch_predict   prediction that was made for the EX branch in ID
//   ex_branch_pc        PC of the EX-stage branch
//   ex_taken            actual branch outcome
//   ex_fail_pc          alternate-path PC to fetch from on a mispredict
//   redirect_valid      registered flush/redirect pulse to fetch
//   redirect_pc         registered redirect address
//   branch_count        number of resolved (non-squashed) branches
//   mispredict_count    number of resolved mispredictions

module branch_predict_resolver #(
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_lookup_valid,
  input  logic [31:0] id_lookup_pc,
  output logic        predict_taken,
  input  logic        ex_branch_inst,
  input  logic        ex_branch_predict,
  input  logic [31:0] ex_branch_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_fail_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0]          counters [DEPTH];
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] update_idx;
  logic                squash;
  logic                res;
  logic                mis;

  assign lookup_idx = id_lookup_pc[IDX_BITS+1:2];
  assign update_idx = ex_branch_pc[IDX_BITS+1:2];

  // The cycle right after a redirect holds a wrong-path instruction in EX.
  assign squash = redirect_valid;

  // res gates everything else, so X on the ex_* data fields of a bubble
  // (ex_branch_inst = 0) never reaches any state.
  assign res = ex_branch_inst & ~squash;
  assign mis = res & (ex_branch_predict != ex_taken);

  // Reads the pre-edge table: an update in the same cycle shows up next cycle.
  assign predict_taken = id_lookup_valid & counters[lookup_idx][1];

  // Counter training, saturating at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        counters[i] <= CNT_INIT;
      end
    end else if (res) begin
      if (ex_taken) begin
        if (counters[update_idx] != 2'b11) begin
          counters[update_idx] <= counters[update_idx] + 2'b01;
        end
      end else begin
        if (counters[update_idx] != 2'b00) begin
          counters[update_idx] <= counters[update_idx] - 2'b01;
        end
      end
    end
  end

  // redirect_pc holds its last value between mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      redirect_valid <= mis;
      if (mis) begin
        redirect_pc <= ex_fail_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (res) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mis) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule
